lsu: RTL

Load/store unit: responder side of the execute unit's memory-operand outputs. Takes the effective address (`addr_csr_out`) and store data (`data_out`) produced by `exu` during the memory phase, runs one or two word-aligned transactions on the data bus with byte enables, and returns sign- or zero-extended load data plus a ready level to the core sequencer.

---
 rtl/lsu_pkg.sv | 58 +++++
 rtl/lsu_align.sv | 42 ++++
 rtl/lsu.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, constants and op decode for the load/store unit
package lsu_pkg;

    localparam logic [2:0] MEM_STATU_DEF = 3'b010;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_W32,
        OP_W16,
        OP_W8,
        OP_R32,
        OP_R16,
        OP_R16U,
        OP_R8,
        OP_R8U
    } op_t;

    // Decode may assert several op strobes; the highest-priority one wins.
    function automatic op_t op_select(
        input logic w32, input logic w16, input logic w8, input logic r32,
        input logic r16, input logic r16u, input logic r8, input logic r8u
    );
        if (w32)  return OP_W32;
        if (w16)  return OP_W16;
        if (w8)   return OP_W8;
        if (r32)  return OP_R32;
        if (r16)  return OP_R16;
        if (r16u) return OP_R16U;
        if (r8)   return OP_R8;
        if (r8u)  return OP_R8U;
        return OP_NONE;
    endfunction

    function automatic logic op_is_store(input op_t op);
        return (op == OP_W32) || (op == OP_W16) || (op == OP_W8);
    endfunction

    function automatic logic [3:0] op_base_be(input op_t op);
        case (op)
            OP_W8, OP_R8, OP_R8U:    return BE_B;
            OP_W16, OP_R16, OP_R16U: return BE_H;
            OP_W32, OP_R32:          return BE_W;
            default:                 return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, misalignment detect and load extract/extend
module lsu_align
    import lsu_pkg::*;
(
    input  op_t         op,
    input  logic [1:0]  k,
    input  logic        beat,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata0,
    input  logic [31:0] rdata1,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [3:0]  base_be;
    logic [5:0]  shamt;
    logic [31:0] shifted;

    // Beat 0 carries the low part of the shifted access, beat 1 the spill into the next word.
    always_comb begin
        base_be    = op_base_be(op);
        shamt      = {1'b0, k, 3'b000};
        be         = beat ? (base_be >> (3'd4 - {1'b0, k})) : (base_be << k);
        lane_wdata = beat ? (wdata >> (6'd32 - shamt)) : (wdata << shamt);
        shifted    = (rdata0 >> shamt) | (rdata1 << (6'd32 - shamt));
        case (op)
            OP_R8:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_R8U:  load_data = {24'h000000, shifted[7:0]};
            OP_R16:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_R16U: load_data = {16'h0000, shifted[15:0]};
            default: load_data = shifted;
        endcase
        case (op)
            OP_W16, OP_R16, OP_R16U: misaligned = (k == 2'd3);
            OP_W32, OP_R32:          misaligned = (k != 2'd0);
            default:                 misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit top; LSU_MISALIGN_EN splits misaligned accesses into two beats
module lsu #(
    parameter logic [2:0] MEM_STATU = lsu_pkg::MEM_STATU_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  statu,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        w8,
    input  logic        w16,
    input  logic        w32,
    input  logic        r8,
    input  logic        r16,
    input  logic        r32,
    input  logic        r8u,
    input  logic        r16u,
    output logic [31:0] rdata_out,
    output logic        rdy_lsu,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    import lsu_pkg::*;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic        misalign_q, misalign_d;

    op_t         op_in, op_cur;
    logic [1:0]  k_cur;
    logic        armed, start, beat1, in_acc;
    logic [31:0] rd0, rd1;
    logic [3:0]  be;
    logic [31:0] lane_wdata, load_data;
    logic        misaligned, need_split, skip_bus;

    assign op_in  = op_select(w32, w16, w8, r32, r16, r16u, r8, r8u);
    assign armed  = (statu == MEM_STATU);
    assign start  = (state_q == ST_IDLE) && armed && (op_in != OP_NONE);
    assign beat1  = (state_q == ST_ACC1);
    assign in_acc = (state_q == ST_ACC0) || beat1;

    // In IDLE the aligner judges the incoming op; afterwards it works on the captured one.
    assign op_cur = (state_q == ST_IDLE) ? op_in : op_q;
    assign k_cur  = (state_q == ST_IDLE) ? addr[1:0] : addr_q[1:0];
    assign rd0    = beat1 ? rdata0_q : bus_rdata;
    assign rd1    = beat1 ? bus_rdata : 32'h0000_0000;

`ifdef LSU_MISALIGN_EN
    assign need_split = misaligned;
    assign skip_bus   = 1'b0;
`else
    assign need_split = 1'b0;
    assign skip_bus   = misaligned;
`endif

    lsu_align u_align (
        .op         (op_cur),
        .k          (k_cur),
        .beat       (beat1),
        .wdata      (wdata_q),
        .rdata0     (rd0),
        .rdata1     (rd1),
        .be         (be),
        .lane_wdata (lane_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // State and operand registers; reset also drops bus_req at once since it decodes state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NONE;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            rdata_q    <= 32'h0000_0000;
            rdata0_q   <= 32'h0000_0000;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rdata0_q   <= rdata0_d;
            misalign_q <= misalign_d;
        end
    end

    // Next state: DONE waits for statu to leave so a held op does not retrigger.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = skip_bus ? ST_DONE : ST_ACC0;
            ST_ACC0: if (bus_ack)   state_d = need_split ? ST_ACC1 : ST_DONE;
            ST_ACC1: if (bus_ack)   state_d = ST_DONE;
            ST_DONE: if (!armed)    state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Operand capture on IDLE exit, first-beat data hold, load result update entering DONE.
    always_comb begin
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rdata0_d   = rdata0_q;
        misalign_d = misalign_q;
        if (start) begin
            op_d       = op_in;
            addr_d     = addr;
            wdata_d    = wdata;
            misalign_d = skip_bus;
            if (skip_bus) begin
                rdata_d = 32'h0000_0000;
            end
        end
        if ((state_q == ST_ACC0) && bus_ack) begin
            rdata0_d = bus_rdata;
        end
        if (in_acc && bus_ack && (state_d == ST_DONE) && !op_is_store(op_q)) begin
            rdata_d = load_data;
        end
    end

    // Outputs decoded from registered state; bus fields are quiet outside an access.
    always_comb begin
        bus_req   = in_acc;
        rdy_lsu   = (state_q == ST_DONE);
        misalign  = misalign_q;
        rdata_out = rdata_q;
        bus_we    = in_acc && op_is_store(op_q);
        bus_addr  = in_acc ? ({addr_q[31:2], 2'b00} + (beat1 ? 32'd4 : 32'd0)) : 32'h0000_0000;
        bus_be    = in_acc ? be : 4'b0000;
        bus_wdata = in_acc ? lane_wdata : 32'h0000_0000;
    end

endmodule
